// File: rtl/frame_streamer_pkg.sv
// Shared definitions for frame_streamer and its position tracker.
// FSM state encoding and window geometry.
package frame_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int WIN_K = 5;

endpackage

// File: rtl/frame_streamer_raster_pos_counter.sv
// Purpose: raster (row, col) tracker; col wraps SIZE-1 -> 0 and bumps row.
// Latency: position updates on the edge after en; clr has priority over en.
// Backpressure: none, advances only when en is high.
module raster_pos_counter #(
    parameter int SIZE  = 32,
    parameter int POS_W = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [POS_W-1:0] r,
    output logic [POS_W-1:0] c
);

    localparam logic [POS_W-1:0] LAST = POS_W'(SIZE - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
            c <= '0;
        end else if (clr) begin
            r <= '0;
            c <= '0;
        end else if (en) begin
            if (c == LAST) begin
                c <= '0;
                r <= (r == LAST) ? '0 : r + 1'b1;
            end else begin
                c <= c + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_streamer.sv
// Purpose: raster-order pixel source for a 5x5 window buffer, fed from a 1-cycle sync RAM.
// Latency: pixel appears 2 cycles after its address; SIZE*SIZE+3 cycles start to done.
// Backpressure: FRAME_STALL_EN defined -> stall holds new reads; undefined -> stall ignored.
module frame_streamer
    import frame_streamer_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int SIZE      = 32,
    localparam int ADDR_W   = $clog2(SIZE * SIZE)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        stall,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic                        ram_re,
    input  logic signed [BIT_WIDTH-1:0] ram_dout,
    output logic signed [BIT_WIDTH-1:0] pix,
    output logic                        pix_en,
    output logic                        win_valid,
    output logic                        busy,
    output logic                        done
);

    localparam int POS_W = $clog2(SIZE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE * SIZE - 1);
    localparam logic [POS_W-1:0]  LAST_POS  = POS_W'(SIZE - 1);
    localparam logic [POS_W-1:0]  WIN_EDGE  = POS_W'(WIN_K - 1);

    state_t           state, state_nxt;
    logic             stall_eff;
    logic             start_acc;
    logic             rd_inflight;
    logic             last_pix;
    logic [POS_W-1:0] r, c;

`ifdef FRAME_STALL_EN
    assign stall_eff = stall;
`else
    logic stall_unused;
    assign stall_unused = stall;
    assign stall_eff    = 1'b0;
`endif

    assign start_acc = start && (state == ST_IDLE);
    // (r,c) are the coordinates of the pixel currently presented on pix
    assign last_pix  = pix_en && (r == LAST_POS) && (c == LAST_POS);

    always_comb begin
        state_nxt = state;
        ram_re    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_READ;
            end
            ST_READ: begin
                busy   = 1'b1;
                ram_re = !stall_eff;
                if (ram_re && (ram_addr == LAST_ADDR)) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (last_pix) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ram_addr    <= '0;
            rd_inflight <= 1'b0;
            pix         <= '0;
            pix_en      <= 1'b0;
            win_valid   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_acc)
                ram_addr <= '0;
            else if (ram_re && (ram_addr != LAST_ADDR))
                ram_addr <= ram_addr + 1'b1;
            rd_inflight <= ram_re;
            pix_en      <= rd_inflight;
            if (rd_inflight) pix <= ram_dout;
            // row-straddling positions (c < WIN_K-1) never form a real window
            win_valid <= pix_en && (r >= WIN_EDGE) && (c >= WIN_EDGE);
        end
    end

    raster_pos_counter #(
        .SIZE  (SIZE),
        .POS_W (POS_W)
    ) u_pos (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_acc),
        .en    (pix_en),
        .r     (r),
        .c     (c)
    );

endmodule
